// File: rtl/inv_salsa20_core_pkg.sv
// inv_salsa20_core_pkg: shared word type, rotation constants, index tables and packing helpers
package inv_salsa20_core_pkg;
  typedef logic [31:0] word_t;
  typedef word_t words_t [16];
  typedef logic [3:0] idx_t;
  localparam int ROT_A = 18;
  localparam int ROT_D = 13;
  localparam int ROT_C = 9;
  localparam int ROT_B = 7;
  // Tuples are (a,b,c,d) for each of the four parallel quarter rounds
  localparam idx_t ROW_IDX [4][4] = '{'{4'd0, 4'd1, 4'd2, 4'd3}, '{4'd5, 4'd6, 4'd7, 4'd4},
                                      '{4'd10, 4'd11, 4'd8, 4'd9}, '{4'd15, 4'd12, 4'd13, 4'd14}};
  localparam idx_t COL_IDX [4][4] = '{'{4'd0, 4'd4, 4'd8, 4'd12}, '{4'd5, 4'd9, 4'd13, 4'd1},
                                      '{4'd10, 4'd14, 4'd2, 4'd6}, '{4'd15, 4'd3, 4'd7, 4'd11}};
  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic words_t to_words(input logic [511:0] v);
    words_t w;
    for (int i = 0; i < 16; i++) w[i] = v[32*i +: 32];
    return w;
  endfunction
  function automatic logic [511:0] from_words(input words_t w);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = w[i];
    return v;
  endfunction
endpackage

// File: rtl/inv_salsa20_core_if.sv
// inv_salsa20_core_if: valid/ready input and output streams plus busy status
interface inv_salsa20_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] data_out;
  logic         busy;
  modport master (output in_valid, data_in, out_ready, input in_ready, out_valid, data_out, busy);
  modport slave  (input in_valid, data_in, out_ready, output in_ready, out_valid, data_out, busy);
endinterface

// File: rtl/inv_salsa20_core_qr.sv
// inv_quarter_round: combinational inverse Salsa20 quarter round, steps undone in reverse order
module inv_quarter_round
  import inv_salsa20_core_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  word_t i_c,
  input  word_t i_d,
  output word_t o_a,
  output word_t o_b,
  output word_t o_c,
  output word_t o_d
);
  word_t w_a, w_c, w_d;
  assign w_a = i_a ^ rotl(i_d + i_c, ROT_A);
  assign w_d = i_d ^ rotl(i_c + i_b, ROT_D);
  assign w_c = i_c ^ rotl(i_b + w_a, ROT_C);
  assign o_b = i_b ^ rotl(w_a + w_d, ROT_B);
  assign o_a = w_a;
  assign o_c = w_c;
  assign o_d = w_d;
endmodule

// File: rtl/inv_salsa20_core.sv
// inv_salsa20_core: iterative inverse Salsa20 rounds, one half-round per clock
// Even counter values undo a row round, odd values undo a column round.
module inv_salsa20_core
  import inv_salsa20_core_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input logic              clk,
  input logic              rst_n,
  inv_salsa20_core_if.slave bus
);
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t           r_fsm;
  logic [511:0]   r_st, r_out;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready, r_out_valid, r_busy;
  words_t         w_cur, w_nxt;
  word_t          w_qi [4][4];
  word_t          w_qo [4][4];
  always_comb begin
    w_cur = to_words(r_st);
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 4; k++)
        w_qi[q][k] = w_cur[r_cnt[0] ? COL_IDX[q][k] : ROW_IDX[q][k]];
  end
  for (genvar g = 0; g < 4; g++) begin : g_qr
    inv_quarter_round u_qr (
      .i_a(w_qi[g][0]), .i_b(w_qi[g][1]), .i_c(w_qi[g][2]), .i_d(w_qi[g][3]),
      .o_a(w_qo[g][0]), .o_b(w_qo[g][1]), .o_c(w_qo[g][2]), .o_d(w_qo[g][3])
    );
  end
  // The four tuples partition all 16 words, so every word is rewritten
  always_comb begin
    w_nxt = w_cur;
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 4; k++)
        w_nxt[r_cnt[0] ? COL_IDX[q][k] : ROW_IDX[q][k]] = w_qo[q][k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_st        <= '0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: if (bus.in_valid) begin
          r_st       <= bus.data_in;
          r_cnt      <= '0;
          r_fsm      <= RUN;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        RUN: begin
          r_st  <= from_words(w_nxt);
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_fsm       <= DONE;
            r_out       <= from_words(w_nxt);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          r_fsm       <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_out;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_inv_salsa20_core.sv
// tb_inv_salsa20_core: randomized round-trip bench against a forward Salsa20 reference
module tb_inv_salsa20_core;
  localparam int CT [4][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11}};
  localparam int RT [4][4] = '{'{0, 1, 2, 3}, '{5, 6, 7, 4}, '{10, 11, 8, 9}, '{15, 12, 13, 14}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] qa, qb, qc, qd, qoa, qob, qoc, qod;
  inv_salsa20_core_if bus ();
  inv_salsa20_core_if if8 ();
  inv_salsa20_core_if if12 ();
  inv_salsa20_core #(.ROUNDS(20)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  inv_salsa20_core #(.ROUNDS(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  inv_salsa20_core #(.ROUNDS(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(if12));
  inv_quarter_round u_qr (.i_a(qa), .i_b(qb), .i_c(qc), .i_d(qd), .o_a(qoa), .o_b(qob), .o_c(qoc), .o_d(qod));
  always #5 clk = ~clk;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  // Forward Salsa20: column round first, then row round, alternating
  function automatic logic [511:0] fwd(input logic [511:0] s, input int rounds);
    logic [31:0] w [16];
    logic [511:0] r;
    int t [4];
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int h = 0; h < rounds; h++)
      for (int q = 0; q < 4; q++) begin
        for (int k = 0; k < 4; k++) t[k] = (h % 2 == 0) ? CT[q][k] : RT[q][k];
        w[t[1]] = w[t[1]] ^ rl(w[t[0]] + w[t[3]], 7);
        w[t[2]] = w[t[2]] ^ rl(w[t[1]] + w[t[0]], 9);
        w[t[3]] = w[t[3]] ^ rl(w[t[2]] + w[t[1]], 13);
        w[t[0]] = w[t[0]] ^ rl(w[t[3]] + w[t[2]], 18);
      end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction
  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [511:0] din, output logic [511:0] dout, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    bus.data_in = din;
    bus.in_valid = 1'b1;
    lat = 0;
    dout = '0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (!bus.in_ready) bus.in_valid = 1'b0;
      if (bus.out_valid) begin lat = c; dout = bus.data_out; break; end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags got ir/ov/busy=%b want 100", {bus.in_ready, bus.out_valid, bus.busy});
    end
    n_checks++;
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.data_out); end
  endtask

  task automatic test_quarter_round();
    logic [31:0] a, b, c, d, b2, c2, d2, a2;
    qa = 32'h08008145; qb = 32'h00000080; qc = 32'h00010200; qd = 32'h20500000;
    #1;
    n_checks++;
    if ({qoa, qob, qoc, qod} !== {32'h1, 32'h0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL qr_vector got %h %h %h %h want 1 0 0 0", qoa, qob, qoc, qod);
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      b2 = b ^ rl(a + d, 7); c2 = c ^ rl(b2 + a, 9); d2 = d ^ rl(c2 + b2, 13); a2 = a ^ rl(d2 + c2, 18);
      qa = a2; qb = b2; qc = c2; qd = d2;
      #1;
      n_checks++;
      if ({qoa, qob, qoc, qod} !== {a, b, c, d}) begin
        n_fail++; $display("FAIL qr_random got %h %h %h %h want %h %h %h %h", qoa, qob, qoc, qod, a, b, c, d);
      end
    end
  endtask

  task automatic test_zero();
    logic [511:0] y;
    int lat;
    run_block('0, y, lat);
    n_checks++;
    if (lat != 21) begin n_fail++; $display("FAIL zero_latency got %0d want 21", lat); end
    n_checks++;
    if (y !== '0) begin n_fail++; $display("FAIL zero_data got %h want 0", y); end
  endtask

  task automatic test_round_trip(input int n);
    logic [511:0] x, y;
    int lat;
    for (int v = 0; v < n; v++) begin
      x = rand512();
      run_block(fwd(x, 20), y, lat);
      n_checks++;
      if (lat != 21) begin n_fail++; $display("FAIL rt20_latency vec %0d got %0d want 21", v, lat); end
      n_checks++;
      if (y !== x) begin n_fail++; $display("FAIL rt20_data vec %0d got %h want %h", v, y, x); end
    end
  endtask

  task automatic test_variants(input int n);
    logic [511:0] x;
    int n8, n12, w;
    for (int v = 0; v < n; v++) begin
      x = rand512();
      w = 0;
      while (!(if8.in_ready && if12.in_ready) && w < 50) begin tick(); w++; end
      if8.data_in = fwd(x, 8);
      if12.data_in = fwd(x, 12);
      if8.in_valid = 1'b1;
      if12.in_valid = 1'b1;
      tick();
      if8.in_valid = 1'b0;
      if12.in_valid = 1'b0;
      n8 = 0; n12 = 0;
      for (int c = 1; c <= 40 && (n8 == 0 || n12 == 0); c++) begin
        tick();
        if (if8.out_valid && n8 == 0) begin
          n8 = c;
          n_checks++;
          if (if8.data_out !== x) begin n_fail++; $display("FAIL rt8_data got %h want %h", if8.data_out, x); end
        end
        if (if12.out_valid && n12 == 0) begin
          n12 = c;
          n_checks++;
          if (if12.data_out !== x) begin n_fail++; $display("FAIL rt12_data got %h want %h", if12.data_out, x); end
        end
      end
      n_checks++;
      if (n8 != 8 || n12 != 12) begin n_fail++; $display("FAIL variant_latency got %0d/%0d want 8/12", n8, n12); end
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] x, snap;
    int n = 0;
    x = rand512();
    bus.out_ready = 1'b0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    bus.data_in = fwd(x, 20);
    bus.in_valid = 1'b1;
    tick();
    n_checks++;
    if ({bus.in_ready, bus.busy} !== 2'b01) begin
      n_fail++; $display("FAIL bp_run_flags got ir/busy=%b want 01", {bus.in_ready, bus.busy});
    end
    for (int c = 0; c < 19; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.data_in = rand512();
      tick();
    end
    n = 0;
    while (!bus.out_valid && n < 10) begin tick(); n++; end
    snap = bus.data_out;
    n_checks++;
    if (snap !== x) begin n_fail++; $display("FAIL bp_data got %h want %h", snap, x); end
    for (int c = 0; c < 50; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (!(bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.busy === 1'b0 && bus.data_out === snap)) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d got ov/ir/busy=%b data %h want 100 data %h", c,
                 {bus.out_valid, bus.in_ready, bus.busy}, bus.data_out, snap);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.data_out !== snap) begin
      n_fail++; $display("FAIL bp_release got ov/ir=%b data %h want 01 data %h", {bus.out_valid, bus.in_ready}, bus.data_out, snap);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] src [3];
    int acc_c [$];
    int hs_c [$];
    int nres = 0, nacc = 0, n = 0;
    logic prev_ir, prev_ov;
    for (int i = 0; i < 3; i++) src[i] = rand512();
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    bus.out_ready = 1'b1;
    bus.data_in = fwd(src[0], 20);
    bus.in_valid = 1'b1;
    prev_ir = bus.in_ready;
    prev_ov = bus.out_valid;
    for (int cyc = 1; cyc <= 200 && nres < 3; cyc++) begin
      tick();
      if (prev_ir && !bus.in_ready) begin
        acc_c.push_back(cyc);
        nacc++;
        if (nacc < 3) bus.data_in = fwd(src[nacc], 20);
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid && nres < 3) begin
        n_checks++;
        if (bus.data_out !== src[nres]) begin
          n_fail++; $display("FAIL b2b_data blk %0d got %h want %h", nres, bus.data_out, src[nres]);
        end
        nres++;
      end
      if (prev_ov && !bus.out_valid) hs_c.push_back(cyc);
      prev_ir = bus.in_ready;
      prev_ov = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (nres != 3 || acc_c.size() != 3 || hs_c.size() < 2) begin
      n_fail++; $display("FAIL b2b_count got res/acc/hs=%0d/%0d/%0d want 3/3/2+", nres, acc_c.size(), hs_c.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (acc_c[k] != hs_c[k-1] + 1) begin
          n_fail++; $display("FAIL b2b_gap blk %0d got accept %0d want %0d", k, acc_c[k], hs_c[k-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [511:0] x, y;
    int lat, n = 0;
    x = rand512();
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    bus.data_in = fwd(x, 20);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL midrst_flags got ov/busy/ir=%b want 001", {bus.out_valid, bus.busy, bus.in_ready});
    end
    n_checks++;
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL midrst_data got %h want 0", bus.data_out); end
    #3 rst_n = 1'b1;
    x = rand512();
    run_block(fwd(x, 20), y, lat);
    n_checks++;
    if (lat != 21) begin n_fail++; $display("FAIL midrst_latency got %0d want 21", lat); end
    n_checks++;
    if (y !== x) begin n_fail++; $display("FAIL midrst_result got %h want %h", y, x); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.data_in = '0; if8.out_ready = 1'b1;
    if12.in_valid = 1'b0; if12.data_in = '0; if12.out_ready = 1'b1;
    qa = '0; qb = '0; qc = '0; qd = '0;
    #12;
    test_reset();
    #10 rst_n = 1'b1;
    test_quarter_round();
    tick();
    test_zero();
    test_round_trip(1000);
    test_variants(200);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
